// File: rtl/full_adder.sv
// Parameterizable ripple-carry full adder with combinational and registered outputs.
// Optional macro FULL_ADDER_SELFCHECK_EN adds a sticky chk_err output fed by a behavioural cross-check.
module full_adder #(
  parameter int WIDTH   = 1,
  parameter int REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] s_q,
  output logic             cout_q,
  output logic             ovf_q,
`ifdef FULL_ADDER_SELFCHECK_EN
  output logic             valid_q,
  output logic             chk_err
`else
  output logic             valid_q
`endif
);

  logic [WIDTH:0] carry_s;

  // Ripple carry chain; carry_s[i] is the carry into bit i.
  always_comb begin
    carry_s    = {(WIDTH+1){1'b0}};
    s          = {WIDTH{1'b0}};
    carry_s[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]         = a[i] ^ b[i] ^ carry_s[i];
      carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end
    cout = carry_s[WIDTH];
    ovf  = carry_s[WIDTH-1] ^ carry_s[WIDTH];
  end

  generate
    if (REG_OUT == 1) begin : g_reg
      logic [WIDTH-1:0] s_r;
      logic             cout_r;
      logic             ovf_r;
      logic             valid_r;

      // Capture stage: load on valid input, otherwise hold data and drop valid.
      always_ff @(posedge clk) begin
        if (rst) begin
          s_r     <= {WIDTH{1'b0}};
          cout_r  <= 1'b0;
          ovf_r   <= 1'b0;
          valid_r <= 1'b0;
        end else if (in_valid == 1'b1) begin
          s_r     <= s;
          cout_r  <= cout;
          ovf_r   <= ovf;
          valid_r <= 1'b1;
        end else begin
          valid_r <= 1'b0;
        end
      end

      assign s_q     = s_r;
      assign cout_q  = cout_r;
      assign ovf_q   = ovf_r;
      assign valid_q = valid_r;
    end else begin : g_noreg
      assign s_q     = {WIDTH{1'b0}};
      assign cout_q  = 1'b0;
      assign ovf_q   = 1'b0;
      assign valid_q = 1'b0;
    end
  endgenerate

`ifdef FULL_ADDER_SELFCHECK_EN
  // Reference sum built with the synthesis tool's own adder, independent of the ripple chain.
  function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] op_a,
                                             input logic [WIDTH-1:0] op_b,
                                             input logic             op_c);
    ref_sum = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_c};
  endfunction

  logic chk_mismatch_s;
  logic chk_err_r;

  // Compare the ripple result against the reference sum.
  always_comb begin
    if (ref_sum(a, b, cin) != {cout, s}) begin
      chk_mismatch_s = 1'b1;
    end else begin
      chk_mismatch_s = 1'b0;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err_r <= 1'b0;
    end else if (chk_mismatch_s) begin
      chk_err_r <= 1'b1;
    end else begin
      chk_err_r <= chk_err_r;
    end
  end

  assign chk_err = chk_err_r;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Directed testbench for full_adder: WIDTH=1 truth table, WIDTH=8 boundaries,
// WIDTH=4 registered stage, WIDTH=16 random sums (plus chk_err when enabled).
module tb_full_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic iv_off = 1'b0;

  // WIDTH=1 instance
  logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic       s1, co1, ov1, s1q, co1q, ov1q, v1q;
  // WIDTH=8 instance
  logic [7:0] a8 = 8'h00, b8 = 8'h00, s8, s8q;
  logic       c8 = 1'b0, co8, ov8, co8q, ov8q, v8q;
  // WIDTH=4 registered instance
  logic [3:0] a4 = 4'h0, b4 = 4'h0, s4, s4q;
  logic       c4 = 1'b0, iv4 = 1'b0, co4, ov4, co4q, ov4q, v4q;
  // WIDTH=16 instance
  logic [15:0] a16 = 16'h0, b16 = 16'h0, s16, s16q;
  logic        c16 = 1'b0, co16, ov16, co16q, ov16q, v16q;
`ifdef FULL_ADDER_SELFCHECK_EN
  logic ce1, ce8, ce4, ce16;
`endif

  full_adder #(.WIDTH(1), .REG_OUT(1)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(c1), .in_valid(iv_off),
    .s(s1), .cout(co1), .ovf(ov1), .s_q(s1q), .cout_q(co1q), .ovf_q(ov1q),
`ifdef FULL_ADDER_SELFCHECK_EN
    .chk_err(ce1),
`endif
    .valid_q(v1q));

  full_adder #(.WIDTH(8), .REG_OUT(1)) u_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(c8), .in_valid(iv_off),
    .s(s8), .cout(co8), .ovf(ov8), .s_q(s8q), .cout_q(co8q), .ovf_q(ov8q),
`ifdef FULL_ADDER_SELFCHECK_EN
    .chk_err(ce8),
`endif
    .valid_q(v8q));

  full_adder #(.WIDTH(4), .REG_OUT(1)) u_w4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(c4), .in_valid(iv4),
    .s(s4), .cout(co4), .ovf(ov4), .s_q(s4q), .cout_q(co4q), .ovf_q(ov4q),
`ifdef FULL_ADDER_SELFCHECK_EN
    .chk_err(ce4),
`endif
    .valid_q(v4q));

  full_adder #(.WIDTH(16), .REG_OUT(1)) u_w16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(c16), .in_valid(iv_off),
    .s(s16), .cout(co16), .ovf(ov16), .s_q(s16q), .cout_q(co16q), .ovf_q(ov16q),
`ifdef FULL_ADDER_SELFCHECK_EN
    .chk_err(ce16),
`endif
    .valid_q(v16q));

  // Truth table indexed by {a,b,cin}: {cout,s}
  logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  // Back-to-back vectors: a, b, cin, expected s, cout, ovf
  logic [3:0] bb_a  [4] = '{4'h1, 4'h5, 4'hF, 4'h7};
  logic [3:0] bb_b  [4] = '{4'h2, 4'h5, 4'h1, 4'h7};
  logic       bb_c  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [3:0] bb_s  [4] = '{4'h3, 4'hB, 4'h0, 4'hE};
  logic       bb_co [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic       bb_ov [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0]  idx;
    logic [16:0] exp17;
    logic        exp_ov;

    // WIDTH=1: cin toggles every 50 ns, a every 100 ns, b every 300 ns
    for (int t = 0; t < 20; t++) begin
      c1 = t[0];
      a1 = t[1];
      b1 = ((t / 6) % 2) == 1;
      #25;
      idx = {a1, b1, c1};
      chk($sformatf("w1_s_%0d", idx),   {63'd0, s1},  {63'd0, tt[idx][0]});
      chk($sformatf("w1_co_%0d", idx),  {63'd0, co1}, {63'd0, tt[idx][1]});
      chk($sformatf("w1_ovf_%0d", idx), {63'd0, ov1}, {63'd0, tt[idx][1] ^ c1});
      #25;
    end

    // WIDTH=8 boundaries
    a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; #1;
    chk("w8_ff1_s", {56'd0, s8}, 64'h00);
    chk("w8_ff1_co", {63'd0, co8}, 64'd1);
    chk("w8_ff1_ov", {63'd0, ov8}, 64'd0);
    a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0; #1;
    chk("w8_7f1_s", {56'd0, s8}, 64'h80);
    chk("w8_7f1_co", {63'd0, co8}, 64'd0);
    chk("w8_7f1_ov", {63'd0, ov8}, 64'd1);
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; #1;
    chk("w8_wrap_s", {56'd0, s8}, 64'hFF);
    chk("w8_wrap_co", {63'd0, co8}, 64'd1);
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b1; #1;
    chk("w8_zero_s", {56'd0, s8}, 64'h01);
    chk("w8_zero_co", {63'd0, co8}, 64'd0);

    // Registered path: reset two cycles
    @(negedge clk); rst = 1'b1; iv4 = 1'b0;
    step(); step();
    chk("rst_s_q", {60'd0, s4q}, 64'd0);
    chk("rst_valid_q", {63'd0, v4q}, 64'd0);
    chk("rst_cout_q", {63'd0, co4q}, 64'd0);
    @(negedge clk); rst = 1'b0; iv4 = 1'b1; a4 = 4'h3; b4 = 4'h4; c4 = 1'b1;
    step();
    chk("reg_s_q", {60'd0, s4q}, 64'h8);
    chk("reg_cout_q", {63'd0, co4q}, 64'd0);
    chk("reg_ovf_q", {63'd0, ov4q}, 64'd1);
    chk("reg_valid_q", {63'd0, v4q}, 64'd1);
    @(negedge clk); iv4 = 1'b0; a4 = 4'h1; b4 = 4'h1; c4 = 1'b0;
    step();
    chk("hold_valid_q", {63'd0, v4q}, 64'd0);
    chk("hold_s_q", {60'd0, s4q}, 64'h8);
    @(negedge clk); iv4 = 1'bx;
    step();
    chk("x_valid_q", {63'd0, v4q}, 64'd0);
    chk("x_s_q", {60'd0, s4q}, 64'h8);

    // Reset wins over in_valid
    @(negedge clk); rst = 1'b1; iv4 = 1'b1; a4 = 4'h5; b4 = 4'h1; c4 = 1'b0;
    step();
    chk("rstmid_s_q", {60'd0, s4q}, 64'd0);
    chk("rstmid_valid_q", {63'd0, v4q}, 64'd0);
    @(negedge clk); rst = 1'b0; iv4 = 1'b0;

    // Back-to-back
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      iv4 = 1'b1; a4 = bb_a[k]; b4 = bb_b[k]; c4 = bb_c[k];
      step();
      chk($sformatf("b2b_s_q_%0d", k),  {60'd0, s4q},  {60'd0, bb_s[k]});
      chk($sformatf("b2b_co_q_%0d", k), {63'd0, co4q}, {63'd0, bb_co[k]});
      chk($sformatf("b2b_ov_q_%0d", k), {63'd0, ov4q}, {63'd0, bb_ov[k]});
      chk($sformatf("b2b_v_q_%0d", k),  {63'd0, v4q},  64'd1);
    end
    @(negedge clk); iv4 = 1'b0;
    step();
    chk("b2b_end_valid_q", {63'd0, v4q}, 64'd0);

    // WIDTH=16 random vectors against a behavioural model
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c16 = 1'($urandom);
      #1;
      exp17  = {1'b0, a16} + {1'b0, b16} + {16'd0, c16};
      exp_ov = (a16[15] == b16[15]) && (exp17[15] != a16[15]);
      chk("w16_sum", {47'd0, co16, s16}, {47'd0, exp17});
      chk("w16_ovf", {63'd0, ov16}, {63'd0, exp_ov});
    end
    step();
`ifdef FULL_ADDER_SELFCHECK_EN
    chk("w16_chk_err", {63'd0, ce16}, 64'd0);
    chk("w4_chk_err", {63'd0, ce4}, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
